// File: rtl/rxpkt_parse.sv
// rxpkt_parse: fetches a 7-word beacon packet from the 16-bit receive RAM,
// validates checksum/header/ID/range, and hands the fields to qtupdate with a
// two-cycle start strobe followed by a hold-off while the table walk runs.
module rxpkt_parse #(
    parameter logic [3:0] TYPE_BEACON = 4'h1,
    parameter int         PKT_WORDS   = 7,
    parameter int         UPD_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] my_id,
    input  logic        rx_valid,
    input  logic [15:0] rx_base,
    output logic        rx_ready,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic [15:0] nID,
    output logic [15:0] battStat,
    output logic [15:0] qVal,
    output logic [15:0] cID,
    output logic [15:0] sinkID,
    output logic        start,
    output logic        drop,
    output logic [2:0]  drop_code,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0]    LEN_REQ   = 8'(PKT_WORDS);
    localparam int            HW        = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(UPD_CYCLES - 1);
    localparam logic [2:0]    LAST_WORD = 3'd6;
    localparam logic [2:0]    NUM_READS = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_START = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    // Checksum accumulation: plain 16-bit add, carries fall off the top.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        return acc + word;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_rd_cnt;     // reads issued so far
    logic            r_pend;       // a read was issued last cycle, data is on mem_data now
    logic [2:0]      r_cap_idx;    // index of the next word to capture
    logic [15:0]     r_sum;        // running sum of w0..w5
    logic [3:0]      r_type;
    logic [7:0]      r_len;
    logic [15:0]     r_src;
    logic [15:0]     r_batt;
    logic [15:0]     r_qval;
    logic [15:0]     r_cid;
    logic [15:0]     r_sink;
    logic [15:0]     r_csum;
    logic            r_start_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic [2:0]      w_code;

    // Reject reason for the captured packet, first failing rule wins (0 = accept).
    always_comb begin
        w_code = 3'd0;
        if (r_sum != r_csum) begin
            w_code = 3'd1;
        end else if (r_type != TYPE_BEACON) begin
            w_code = 3'd2;
        end else if (r_len != LEN_REQ) begin
            w_code = 3'd3;
        end else if (r_src == my_id) begin
            w_code = 3'd4;
        end else if (r_batt[15] || r_qval[15]) begin
            w_code = 3'd5;
        end else begin
            w_code = 3'd0;
        end
    end

    // Next-state logic of the fetch/validate/handoff sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) w_state_nxt = S_READ;
                else          w_state_nxt = S_IDLE;
            end
            S_READ: begin
                if (r_pend && (r_cap_idx == LAST_WORD)) w_state_nxt = S_CHECK;
                else                                    w_state_nxt = S_READ;
            end
            S_CHECK: begin
                if (w_code == 3'd0) w_state_nxt = S_START;
                else                w_state_nxt = S_IDLE;
            end
            S_START: begin
                if (r_start_cnt) w_state_nxt = S_HOLD;
                else             w_state_nxt = S_START;
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_IDLE;
                else                         w_state_nxt = S_HOLD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Read issue: seven back-to-back word reads starting at the latched base.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd   <= 1'b0;
            mem_addr <= 16'h0000;
            r_rd_cnt <= 3'd0;
            r_pend   <= 1'b0;
        end else begin
            r_pend <= mem_rd;
            if ((r_state == S_IDLE) && rx_valid) begin
                mem_rd   <= 1'b1;
                mem_addr <= rx_base;
                r_rd_cnt <= 3'd1;
            end else if ((r_state == S_READ) && (r_rd_cnt != NUM_READS)) begin
                mem_rd   <= 1'b1;
                mem_addr <= mem_addr + 16'd2;
                r_rd_cnt <= r_rd_cnt + 3'd1;
            end else begin
                mem_rd <= 1'b0;
            end
        end
    end

    // Capture returning words into shadow registers and accumulate the checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_idx <= 3'd0;
            r_sum     <= 16'h0000;
            r_type    <= 4'h0;
            r_len     <= 8'h00;
            r_src     <= 16'h0000;
            r_batt    <= 16'h0000;
            r_qval    <= 16'h0000;
            r_cid     <= 16'h0000;
            r_sink    <= 16'h0000;
            r_csum    <= 16'h0000;
        end else if ((r_state == S_IDLE) && rx_valid) begin
            r_cap_idx <= 3'd0;
            r_sum     <= 16'h0000;
        end else if ((r_state == S_READ) && r_pend) begin
            case (r_cap_idx)
                3'd0: begin
                    r_type <= mem_data[15:12];
                    r_len  <= mem_data[7:0];
                end
                3'd1:    r_src  <= mem_data;
                3'd2:    r_batt <= mem_data;
                3'd3:    r_qval <= mem_data;
                3'd4:    r_cid  <= mem_data;
                3'd5:    r_sink <= mem_data;
                3'd6:    r_csum <= mem_data;
                default: r_csum <= r_csum;
            endcase
            if (r_cap_idx != LAST_WORD) begin
                r_sum <= csum_add(r_sum, mem_data);
            end
            r_cap_idx <= r_cap_idx + 3'd1;
        end
    end

    // Sequencing counters for the start strobe and the hold-off window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_cnt <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_start_cnt <= (r_state == S_START);
            if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + HW'(1);
            else                   r_hold_cnt <= '0;
        end
    end

    // Registered handshake, verdict, field and counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready  <= 1'b1;
            start     <= 1'b0;
            drop      <= 1'b0;
            drop_code <= 3'd0;
            nID       <= 16'h0000;
            battStat  <= 16'h0000;
            qVal      <= 16'h0000;
            cID       <= 16'h0000;
            sinkID    <= 16'h0000;
            pkt_cnt   <= 16'h0000;
            drop_cnt  <= 16'h0000;
        end else begin
            rx_ready <= (w_state_nxt == S_IDLE);
            start    <= (w_state_nxt == S_START);
            drop     <= (r_state == S_CHECK) && (w_code != 3'd0);
            if (r_state == S_CHECK) begin
                if (w_code == 3'd0) begin
                    nID      <= r_src;
                    battStat <= r_batt;
                    qVal     <= r_qval;
                    cID      <= r_cid;
                    sinkID   <= r_sink;
                    pkt_cnt  <= pkt_cnt + 16'd1;
                end else begin
                    drop_code <= w_code;
                    drop_cnt  <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/rxpkt_parse.md
# rxpkt_parse

Upstream stage of `qtupdate`: fetches a received beacon packet from the 16-bit receive RAM and validates header, length, checksum and field ranges. It presents the extracted fields (`nID`, `battStat`, `qVal`, `cID`, `sinkID`) together with a `start` strobe to `qtupdate`. Invalid packets are dropped with a reason code, and the stage is blocked while `qtupdate` walks the neighbour table.

## Interface
Parameters:
- `TYPE_BEACON`, default 4'h1: required header type field.
- `PKT_WORDS`, default 7: required header length field (words, including checksum).
- `UPD_CYCLES`, default 32: hold-off cycles after `start` while `qtupdate` runs; must be ≥1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset. Synchronous and active-high; sampled on the rising edge of `clk`.
- `my_id` input 16: this node's ID.
- `rx_valid` input 1: packet available at `rx_base`. Sampled only when `rx_ready`=1.
- `rx_base` input 16: byte address of packet word 0.
- `rx_ready` output 1: high in IDLE.
- `mem_rd` output 1: RAM read strobe.
- `mem_addr` output 16: RAM byte address. Word stride is 2.
- `mem_data` input 16: RAM read data, valid the cycle after `mem_rd`.
- `nID`, `battStat`, `qVal`, `cID`, `sinkID` output 16 each: fields of the last accepted packet.
- `start` output 1: update strobe to `qtupdate`.
- `drop` output 1: one-cycle pulse on a rejected packet.
- `drop_code` output 3: reason for the last drop.
- `pkt_cnt` output 16: count of accepted packets.
- `drop_cnt` output 16: count of dropped packets.

## Operation
- Packet layout, word k at `rx_base+2k`:
  - w0: header. `[15:12]` type, `[11:8]` reserved, `[7:0]` length.
  - w1: source ID.
  - w2: battStat.
  - w3: qVal.
  - w4: cID.
  - w5: sinkID.
  - w6: checksum.
- Checksum rule: w6 must equal w0+w1+…+w5, truncated to 16 bits. Carries are discarded.
- Address arithmetic is modulo 2^16; `rx_base`=16'hFFFE wraps to 16'h0000 for word 1.
- States:
  - IDLE: `rx_ready`=1. `rx_valid`=1 latches `rx_base` → READ.
  - READ: issues 7 back-to-back reads, k=0..6. Captures `mem_data` one cycle after each read into shadow registers and accumulates the running sum of w0..w5. After w6 is captured → CHECK.
  - CHECK: one cycle, evaluates rejects in priority order (first match wins):
    - 1: checksum mismatch.
    - 2: type ≠ `TYPE_BEACON`.
    - 3: length ≠ `PKT_WORDS`.
    - 4: w1 == `my_id`.
    - 5: battStat[15] or qVal[15] set (negative value).
  - Pass: copy shadow registers to the field outputs, increment `pkt_cnt` → START. Fail: set `drop_code`, increment `drop_cnt` → IDLE.
  - START: `start`=1 for exactly 2 cycles → HOLD.
  - HOLD: counts `UPD_CYCLES` cycles with `start`=0 → IDLE.
- Field outputs change only on pass and are stable from the first `start` cycle until the next accept.
- Both counters wrap modulo 2^16.
- `rx_valid` while `rx_ready`=0 is ignored; no queuing.
- `rst` in any state: immediate return to IDLE, all outputs take reset values, and any in-flight packet is discarded without `start` or `drop`.

## Timing
- Reset values:
  - `rx_ready`=1.
  - `mem_rd`=0.
  - `mem_addr`=0.
  - All fields = 0.
  - `start`=0, `drop`=0, `drop_code`=0.
  - `pkt_cnt`=0, `drop_cnt`=0.
- Cycle 0: `rx_valid` and `rx_ready` both sampled high.
- Cycles 1–7: `mem_rd`=1, `mem_addr`=`rx_base`+2(c−1).
- Cycles 2–8: `mem_data` captured.
- Cycle 8: `mem_rd`=0.
- Cycle 9: CHECK.
- Accept path:
  - Cycles 10–11: `start`=1, fields valid.
  - Cycles 12 to 11+`UPD_CYCLES`: HOLD.
  - `rx_ready`=1 at cycle 12+`UPD_CYCLES`.
- Drop path:
  - Cycle 10: `drop`=1 and `rx_ready`=1 together.
  - A new `rx_valid` in cycle 10 is accepted.
- `drop_code` holds its value until the next drop.

## Test plan
- Valid packet at `rx_base`=16'h0100:
  - Contents: w0=16'h1007, w1=16'h0005, w2=16'h0064, w3=16'h0010, w4=16'h0002, w5=16'h0001, w6=16'h1083; `my_id`=16'h0009.
  - Required: reads at 0100..010C on cycles 1–7; `start` high cycles 10–11 with `nID`=5, `battStat`=100, `qVal`=16, `cID`=2, `sinkID`=1; `pkt_cnt`=1; `rx_ready` back at cycle 44.
- Same packet with w6=16'h1084 → `drop`=1 at cycle 10, `drop_code`=1, `drop_cnt`=1, `start` never asserted, fields remain 0.
- Individual fault packets, each with a correct checksum:
  - type=2 → `drop_code`=2.
  - length=6 → `drop_code`=3.
  - w1=`my_id` → `drop_code`=4.
  - qVal=16'h8000 → `drop_code`=5.
  - Packet with bad type and bad checksum together → `drop_code`=1.
- `rx_base`=16'hFFFC → `mem_addr` sequence FFFC, FFFE, 0000, 0002, 0004, 0006, 0008; the checksum uses the wrapped words.
- `rx_valid` pulses during READ and HOLD are ignored (counters unchanged). `rst` asserted at cycle 5 → next cycle all outputs at reset values; a subsequent valid packet is processed normally.
- Two valid packets back to back with `UPD_CYCLES`=1: second `rx_valid` at cycle 13 is accepted; `pkt_cnt`=2 and the fields update only at the second `start`.
